// File: rtl/spi16_master.sv
// 16-bit SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, one framed
// transfer per accepted start pulse. Every output comes straight from a flop.
module spi16_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        busy,
   output logic        done,
   output logic        nCS,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam int DIV_W   = $clog2(CLK_DIV) + 1;
   localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int GAP_W   = $clog2(GAP_MAX) + 1;

   localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] SETUP_LOAD = GAP_W'(CS_SETUP - 1);
   localparam logic [GAP_W-1:0] HOLD_LOAD  = GAP_W'(CS_HOLD - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state, state_nx;
   logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
   logic [4:0]        bit_cnt, bit_cnt_nx;
   logic [15:0]       tx_sr, tx_sr_nx;
   logic [15:0]       rx_sr, rx_sr_nx;
   logic [15:0]       dout_nx;
   logic              busy_nx, done_nx, ncs_nx, sclk_nx, mosi_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         div_cnt <= '0;
         gap_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         dout    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         nCS     <= 1'b1;
         SCLK    <= 1'b0;
         MOSI    <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_cnt_nx;
         gap_cnt <= gap_cnt_nx;
         bit_cnt <= bit_cnt_nx;
         tx_sr   <= tx_sr_nx;
         rx_sr   <= rx_sr_nx;
         dout    <= dout_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         nCS     <= ncs_nx;
         SCLK    <= sclk_nx;
         MOSI    <= mosi_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      div_cnt_nx = div_cnt;
      gap_cnt_nx = gap_cnt;
      bit_cnt_nx = bit_cnt;
      tx_sr_nx   = tx_sr;
      rx_sr_nx   = rx_sr;
      dout_nx    = dout;
      busy_nx    = busy;
      done_nx    = 1'b0;
      ncs_nx     = nCS;
      sclk_nx    = SCLK;
      mosi_nx    = MOSI;

      case (state)
         IDLE: begin
            ncs_nx  = 1'b1;
            sclk_nx = 1'b0;
            busy_nx = 1'b0;
            if (start) begin
               tx_sr_nx   = din;
               mosi_nx    = din[15];
               ncs_nx     = 1'b0;
               busy_nx    = 1'b1;
               bit_cnt_nx = '0;
               gap_cnt_nx = SETUP_LOAD;
               state_nx   = SETUP;
            end
         end

         SETUP: begin
            if (gap_cnt == '0) begin
               div_cnt_nx = DIV_LOAD;
               state_nx   = SHIFT;
            end else begin
               gap_cnt_nx = gap_cnt - GAP_W'(1);
            end
         end

         // Each divider expiry is one SCLK edge; low->high samples MISO,
         // high->low advances MOSI and counts a completed bit.
         SHIFT: begin
            if (div_cnt == '0) begin
               div_cnt_nx = DIV_LOAD;
               sclk_nx    = ~SCLK;
               if (!SCLK) begin
                  rx_sr_nx = {rx_sr[14:0], MISO};
               end else begin
                  bit_cnt_nx = bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     mosi_nx    = 1'b0;
                     gap_cnt_nx = HOLD_LOAD;
                     state_nx   = HOLD;
                  end else begin
                     mosi_nx  = tx_sr[14];
                     tx_sr_nx = {tx_sr[14:0], 1'b0};
                  end
               end
            end else begin
               div_cnt_nx = div_cnt - DIV_W'(1);
            end
         end

         HOLD: begin
            if (gap_cnt == '0) begin
               ncs_nx   = 1'b1;
               dout_nx  = rx_sr;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt - GAP_W'(1);
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi16_master.sv
// Bench for spi16_master: two instances (default timing and fastest timing)
// checked every cycle against a frame-time model, plus directed literals.
module tb_spi16_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, start;
   logic [1:0][15:0] din;
   wire  [1:0]       ncs, sclk, mosi, busy, done, miso;
   wire  [1:0][15:0] dout;

   logic [1:0]  mode0, mode1;
   logic [1:0]  rnd;
   logic [15:0] sw;
   logic [4:0]  bidx;
   logic        slave_bit, sclk_prev;
   logic        chk_en;
   int          checks, errors;

   assign miso[0] = (mode0 == 2'd0) ? mosi[0] : (mode0 == 2'd1) ? slave_bit : rnd[0];
   assign miso[1] = (mode1 == 2'd0) ? mosi[1] : rnd[1];

   spi16_master u0 (
      .clk(clk), .reset(rst[0]), .start(start[0]), .din(din[0]), .dout(dout[0]),
      .busy(busy[0]), .done(done[0]), .nCS(ncs[0]), .SCLK(sclk[0]), .MOSI(mosi[0]),
      .MISO(miso[0]));

   spi16_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u1 (
      .clk(clk), .reset(rst[1]), .start(start[1]), .din(din[1]), .dout(dout[1]),
      .busy(busy[1]), .done(done[1]), .nCS(ncs[1]), .SCLK(sclk[1]), .MOSI(mosi[1]),
      .MISO(miso[1]));

   // Slave for instance 0: shifts out sw MSB first, next bit after each SCLK fall.
   always @(negedge clk) begin
      if (ncs[0] !== 1'b0) bidx = 5'd0;
      else if (sclk_prev && !sclk[0]) bidx = bidx + 5'd1;
      sclk_prev = sclk[0];
      rnd = 2'($urandom);
   end
   always @* slave_bit = (bidx < 5'd16) ? sw[4'(5'd15 - bidx)] : 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: a frame is just an elapsed-edge count t since acceptance.
   int          S[2] = '{2, 1};
   int          D[2] = '{4, 1};
   int          H[2] = '{2, 1};
   bit          m_act[2]  = '{0, 0};
   bit          m_done[2] = '{0, 0};
   int          m_t[2]    = '{0, 0};
   logic [15:0] m_din[2]  = '{16'h0, 16'h0};
   logic [15:0] m_rx[2]   = '{16'h0, 16'h0};
   logic [15:0] m_dout[2] = '{16'h0, 16'h0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            m_act[i] = 0; m_done[i] = 0; m_dout[i] = 16'h0;
         end else if (!m_act[i]) begin
            m_done[i] = 0;
            if (start[i]) begin
               m_act[i] = 1; m_t[i] = 0; m_din[i] = din[i]; m_rx[i] = 16'h0;
            end
         end else begin
            m_t[i]++;
            m_done[i] = 0;
            if (m_t[i] >= S[i] && m_t[i] < S[i] + 32*D[i] && (m_t[i] - S[i]) % (2*D[i]) == D[i])
               m_rx[i][15 - (m_t[i] - S[i]) / (2*D[i])] = miso[i];
            if (m_t[i] == S[i] + 32*D[i] + H[i]) begin
               m_act[i] = 0; m_done[i] = 1; m_dout[i] = m_rx[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            logic e_sclk, e_mosi;
            int t, s, d;
            t = m_t[i]; s = S[i]; d = D[i];
            e_sclk = 1'b0; e_mosi = 1'b0;
            if (m_act[i]) begin
               if (t >= s && t < s + 32*d) e_sclk = 1'(((t - s) / d) % 2);
               if (t < s + 32*d) e_mosi = m_din[i][15 - ((t < s) ? 0 : (t - s) / (2*d))];
            end
            chk($sformatf("dut%0d_nCS", i),  16'(ncs[i]),  16'(!m_act[i]));
            chk($sformatf("dut%0d_busy", i), 16'(busy[i]), 16'(m_act[i]));
            chk($sformatf("dut%0d_SCLK", i), 16'(sclk[i]), 16'(e_sclk));
            chk($sformatf("dut%0d_MOSI", i), 16'(mosi[i]), 16'(e_mosi));
            chk($sformatf("dut%0d_done", i), 16'(done[i]), 16'(m_done[i]));
            chk($sformatf("dut%0d_dout", i), dout[i], m_dout[i]);
         end
      end
   end

   task automatic launch(input int i, input logic [15:0] d);
      din[i] = d;
      start[i] = 1'b1;
   endtask

   // Follows one frame from the accepting edge; e = index of the edge just passed.
   task automatic track(input int i, input int inj_e, input logic [15:0] inj_d, input int rst_e,
                        output int de, output int rises, output int lows, output int mhi,
                        output int r1, output int r2, output logic first_ncs);
      logic prev;
      prev = 1'b0; de = -1; rises = 0; lows = 0; mhi = 0; r1 = -1; r2 = -1; first_ncs = 1'bx;
      for (int e = 0; e < 1000; e++) begin
         @(negedge clk);
         if (e == 0) begin start[i] = 1'b0; first_ncs = ncs[i]; end
         if (e == inj_e) begin start[i] = 1'b1; din[i] = inj_d; end
         if (e == inj_e + 1) start[i] = 1'b0;
         if (sclk[i] && !prev) begin
            rises++;
            if (r1 < 0) r1 = e; else if (r2 < 0) r2 = e;
         end
         prev = sclk[i];
         if (!ncs[i]) lows++;
         if (mosi[i]) mhi++;
         if (e == rst_e) begin rst[i] = 1'b1; return; end
         if (done[i]) begin de = e; return; end
      end
      checks++; errors++;
      $display("FAIL track_timeout dut%0d: no done within 1000 cycles", i);
   endtask

   int de, rises, lows, mhi, r1, r2;
   logic fn;
   logic [15:0] d;

   initial begin
      checks = 0; errors = 0; chk_en = 1'b0;
      rst = 2'b11; start = 2'b00; din = '0;
      mode0 = 2'd0; mode1 = 2'd0; sw = 16'h0; bidx = 5'd0; sclk_prev = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_nCS", 16'(ncs[0]), 16'h1);
      chk("reset_SCLK", 16'(sclk[0]), 16'h0);
      chk("reset_busy", 16'(busy[0]), 16'h0);
      chk("reset_dout", dout[0], 16'h0000);
      rst = 2'b00;
      @(negedge clk);

      // loopback
      launch(0, 16'hA5C3);
      track(0, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t1_dout", dout[0], 16'hA5C3);
      chk("t1_model_dout", m_dout[0], 16'hA5C3);
      chk("t1_done_edge", 16'(de), 16'd132);
      chk("t1_rises", 16'(rises), 16'd16);
      chk("t1_ncs_low", 16'(lows), 16'd132);
      chk("t1_rise_gap", 16'(r2 - r1), 16'd8);

      // slave word, all-ones transmit
      mode0 = 2'd1; sw = 16'h3C5A;
      @(negedge clk);
      launch(0, 16'hFFFF);
      track(0, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t2_dout", dout[0], 16'h3C5A);
      chk("t2_mosi_high", 16'(mhi), 16'd130);
      chk("t2_mosi_after", 16'(mosi[0]), 16'h0);

      // back-to-back via start on the done cycle
      sw = 16'h1234;
      @(negedge clk);
      launch(0, 16'h5A5A);
      track(0, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t3_first_dout", dout[0], 16'h1234);
      chk("t3_gap_ncs_high", 16'(ncs[0]), 16'h1);
      sw = 16'hC3A5;
      launch(0, 16'h0001);
      track(0, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t3_gap_ncs_low", 16'(fn), 16'h0);
      chk("t3_second_dout", dout[0], 16'hC3A5);
      chk("t3_second_done_edge", 16'(de), 16'd132);

      // start while busy is ignored
      mode0 = 2'd0; d = 16'($urandom);
      @(negedge clk);
      launch(0, d);
      track(0, 40, ~d, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t4_dout", dout[0], d);
      chk("t4_done_edge", 16'(de), 16'd132);
      repeat (5) begin
         @(negedge clk);
         chk("t4_no_restart", 16'({ncs[0], busy[0]}), 16'b10);
      end

      // reset mid-transfer
      launch(0, 16'h6D2B);
      track(0, -1, 16'h0, 60, de, rises, lows, mhi, r1, r2, fn);
      @(negedge clk);
      chk("t5_nCS", 16'(ncs[0]), 16'h1);
      chk("t5_SCLK", 16'(sclk[0]), 16'h0);
      chk("t5_busy", 16'(busy[0]), 16'h0);
      chk("t5_dout", dout[0], 16'h0000);
      chk("t5_done", 16'(done[0]), 16'h0);
      chk("t5_no_done_seen", 16'(de), 16'hFFFF);
      rst[0] = 1'b0;
      @(negedge clk);
      launch(0, 16'hBEEF);
      track(0, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t5_after_dout", dout[0], 16'hBEEF);
      chk("t5_after_done_edge", 16'(de), 16'd132);

      // random MISO, random din, random gaps and stray starts
      mode0 = 2'd2;
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         launch(0, 16'($urandom));
         track(0, (k % 2) ? int'($urandom_range(1, 120)) : -1, 16'($urandom), -1,
               de, rises, lows, mhi, r1, r2, fn);
         chk("rand0_done_edge", 16'(de), 16'd132);
      end

      // fastest timing instance
      @(negedge clk);
      launch(1, 16'h8001);
      track(1, -1, 16'h0, -1, de, rises, lows, mhi, r1, r2, fn);
      chk("t6_dout", dout[1], 16'h8001);
      chk("t6_done_edge", 16'(de), 16'd34);
      chk("t6_rises", 16'(rises), 16'd16);
      chk("t6_sclk_period", 16'(r2 - r1), 16'd2);
      chk("t6_ncs_low", 16'(lows), 16'd34);

      mode1 = 2'd1;
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         launch(1, 16'($urandom));
         track(1, (k % 2) ? int'($urandom_range(1, 30)) : -1, 16'($urandom), -1,
               de, rises, lows, mhi, r1, r2, fn);
         chk("rand1_done_edge", 16'(de), 16'd34);
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi16_master.md
Name: spi16_master

Overview:
- 16-bit SPI initiator (mode 0, CPOL=0/CPHA=0, MSB first) that drives the ADC SPI bus from the FPGA fabric.
- It is the initiator counterpart of the existing spi16 responder that serves the Raspberry Pi.
- A single `start` pulse runs one framed transfer: nCS is asserted, 16 SCLK periods are driven, then nCS is released.
- The received word is returned on `dout` together with a one-cycle `done` strobe.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (SCLK = f_clk / (2*CLK_DIV)); legal values >= 1.
- CS_SETUP, 2: clk cycles from nCS falling to the start of the first SCLK low half; legal values >= 1.
- CS_HOLD, 2: clk cycles from the last SCLK falling edge to nCS rising; legal values >= 1.

Ports:
- clk  input  1  system clock (PLL output); every register is in this domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only when busy=0.
- din  input  16  word to transmit; latched on the accepting edge.
- dout  output  16  last received word; valid from the done edge until the next done.
- busy  output  1  high from the accepting edge until the done edge.
- done  output  1  one-cycle pulse marking the end of a transfer.
- nCS  output  1  chip select, active low.
- SCLK  output  1  serial clock; idles low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in; already synchronous to the slave, no synchronizer inside this block.

Behaviour:
- Reset (any clk edge with reset=1): nCS=1, SCLK=0, MOSI=0, busy=0, done=0, dout=16'h0000, state=IDLE.
  - Reset mid-transfer aborts the transfer: nCS goes high on that same edge, no done pulse, dout unchanged from its reset value.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - nCS=1, SCLK=0, busy=0.
  - At an edge where start=1: latch din into the TX shift register, nCS<=0, MOSI<=din[15], busy<=1, go to SETUP.
- SETUP: hold for CS_SETUP cycles, then go to SHIFT.
- SHIFT:
  - SCLK toggles every CLK_DIV cycles, starting low; 16 full periods in total (32*CLK_DIV cycles).
  - Rising edge (the clk edge that sets SCLK 0->1): capture MISO into RX shift register bit position 15-k for bit k.
  - Falling edge (the clk edge that sets SCLK 1->0): present the next TX bit on MOSI. After the 16th fall, MOSI<=0 and go to HOLD.
- HOLD:
  - SCLK=0 for CS_HOLD cycles.
  - On the exit edge: nCS<=1, dout<=RX register, done<=1, busy<=0, go to IDLE.
- done is high for exactly one cycle.
- start is ignored whenever busy=1; requests are not queued.
- Back-to-back transfers:
  - start=1 on the edge where done=1 is accepted.
  - nCS is then high for exactly one clk cycle between transfers.
- Timing with default parameters (edge 0 = accepting edge):
  - nCS falls at edge 0 and SHIFT begins at edge 2.
  - SCLK rises at 6, 14, …, 126 (rise k at 8k-2).
  - SCLK falls at 10, 18, …, 130.
  - nCS rises and done=1 at edge 132.
- General transfer length: CS_SETUP + 32*CLK_DIV + CS_HOLD clk cycles from the accepting edge to the done edge.
- Internal counters: bit counter 5 bits (0..16); divider counter width = clog2(CLK_DIV)+1; the divider is reloaded on every SCLK toggle.

Test Plan:
1. Loopback: tie MISO=MOSI, start with din=16'hA5C3 -> dout=16'hA5C3 and done at edge 132.
   - 16 SCLK rising edges; nCS low for exactly 132 cycles.
2. Slave model returns 16'h3C5A MSB-first, changing data on SCLK falls; din=16'hFFFF -> dout=16'h3C5A.
   - MOSI stays high for the whole frame and is 0 after the frame.
3. Assert start on the done edge with din=16'h0001 -> second transfer is accepted, nCS is high for exactly 1 cycle.
   - Second dout matches the slave model's second word.
4. Pulse start at cycle 40 of an active transfer with a different din -> ignored.
   - First transfer completes unchanged and no second transfer starts.
5. Assert reset at cycle 60 of a transfer -> next edge nCS=1, SCLK=0, busy=0, dout=16'h0000, no done.
   - A new start afterwards completes normally.
6. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, loopback din=16'h8001 -> dout=16'h8001, done at edge 34, SCLK period 2 cycles.
